ladybird_bus_router: RTL and testbench

Parametrised address router between one core bus initiator (I_BUS or D_BUS side) and N_TARGET memory/peripheral targets. It generalises the fixed 4-bit region decode (UART/GPIO/BRAM/IRAM/DRAM) into a configurable region table with an optional unmapped-address error target. It tracks up to MAX_OUTSTANDING in-flight requests so responses return to the initiator in issue order. It sits between the core's bus port and the memory-system targets.

---
 rtl/ladybird_bus_router_if.sv | 41 ++++
 rtl/ladybird_bus_router.sv | 124 ++++++++++++
 tb/tb_ladybird_bus_router.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ladybird_bus_router_if.sv
// Bus bundle between the core initiator, the router and its N_TARGET targets.
// master = initiator and target side of the environment, slave = the router.
interface ladybird_bus_router_if #(
    parameter int N_TARGET = 5,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic                             i_req_valid;
    logic                             i_req_ready;
    logic [ADDR_W-1:0]                i_req_addr;
    logic [DATA_W-1:0]                i_req_wdata;
    logic [DATA_W/8-1:0]              i_req_wstrb;
    logic                             i_req_write;
    logic                             i_resp_valid;
    logic                             i_resp_ready;
    logic [DATA_W-1:0]                i_resp_data;
    logic                             i_resp_error;
    logic [N_TARGET-1:0]              t_req_valid;
    logic [N_TARGET-1:0]              t_req_ready;
    logic [ADDR_W-1:0]                t_req_addr;
    logic [DATA_W-1:0]                t_req_wdata;
    logic [DATA_W/8-1:0]              t_req_wstrb;
    logic                             t_req_write;
    logic [N_TARGET-1:0]              t_resp_valid;
    logic [N_TARGET-1:0]              t_resp_ready;
    logic [N_TARGET-1:0][DATA_W-1:0]  t_resp_data;

    modport master (
        output i_req_valid, i_req_addr, i_req_wdata, i_req_wstrb, i_req_write, i_resp_ready,
        output t_req_ready, t_resp_valid, t_resp_data,
        input  i_req_ready, i_resp_valid, i_resp_data, i_resp_error,
        input  t_req_valid, t_req_addr, t_req_wdata, t_req_wstrb, t_req_write, t_resp_ready
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_req_wdata, i_req_wstrb, i_req_write, i_resp_ready,
        input  t_req_ready, t_resp_valid, t_resp_data,
        output i_req_ready, i_resp_valid, i_resp_data, i_resp_error,
        output t_req_valid, t_req_addr, t_req_wdata, t_req_wstrb, t_req_write, t_resp_ready
    );
endinterface

// File: rtl/ladybird_bus_router.sv
// Region-table address router from one initiator to N_TARGET targets, in-order responses.
// Latency: zero-cycle combinational request and response paths; error responses one cycle after accept.
// Backpressure: request stalls on selected target ready or MAX_OUTSTANDING in flight; non-head responses stall.
module ladybird_bus_router #(
    parameter int                              N_TARGET        = 5,
    parameter int                              ADDR_W          = 32,
    parameter int                              DATA_W          = 32,
    parameter int                              REGION_BITS     = 4,
    parameter logic [N_TARGET*REGION_BITS-1:0] REGION_TABLE    = {4'h9, 4'h8, 4'h0, 4'hF, 4'hE},
    parameter logic [N_TARGET-1:0]             REGION_EN       = 5'b11011,
    parameter int                              DEFAULT_TARGET  = 2,
    parameter int                              MAX_OUTSTANDING = 4
) (
    input logic                  clk,
    input logic                  nrst,
    ladybird_bus_router_if.slave bus
);
    localparam int SEL_W = $clog2(N_TARGET + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [REGION_BITS-1:0] tag;
    logic [SEL_W-1:0]       sel;
    logic                   sel_err;

    logic [SEL_W-1:0]       ord_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [SEL_W-1:0]       head;
    logic                   head_err;

    assign tag = bus.i_req_addr[ADDR_W-1 -: REGION_BITS];

    // Entry 0 sits in the most significant slice of REGION_TABLE; walking down keeps the lowest match.
    always_comb begin
        sel = SEL_W'(DEFAULT_TARGET);
        for (int i = N_TARGET - 1; i >= 0; i--) begin
            if (REGION_EN[i] && (tag == REGION_TABLE[(N_TARGET-1-i)*REGION_BITS +: REGION_BITS]))
                sel = SEL_W'(i);
        end
    end

    assign sel_err = (int'(sel) >= N_TARGET);
    assign full    = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count == '0);
    assign head    = ord_mem[rd_ptr];
    assign head_err = (int'(head) >= N_TARGET);

    // Full depends only on registered count, so i_resp_ready never reaches i_req_ready.
    always_comb begin
        bus.t_req_valid = '0;
        bus.i_req_ready = 1'b0;
        if (nrst && !full) begin
            if (sel_err) begin
                bus.i_req_ready = 1'b1;
            end else begin
                for (int i = 0; i < N_TARGET; i++) begin
                    if (sel == SEL_W'(i)) begin
                        bus.t_req_valid[i] = bus.i_req_valid;
                        bus.i_req_ready    = bus.t_req_ready[i];
                    end
                end
            end
        end
    end

    assign bus.t_req_addr  = bus.i_req_addr;
    assign bus.t_req_wdata = bus.i_req_wdata;
    assign bus.t_req_wstrb = bus.i_req_wstrb;
    assign bus.t_req_write = bus.i_req_write;

    always_comb begin
        bus.i_resp_valid = 1'b0;
        bus.i_resp_data  = '0;
        bus.i_resp_error = 1'b0;
        bus.t_resp_ready = '0;
        if (!empty) begin
            if (head_err) begin
                bus.i_resp_valid = 1'b1;
                bus.i_resp_error = 1'b1;
            end else begin
                for (int i = 0; i < N_TARGET; i++) begin
                    if (head == SEL_W'(i)) begin
                        bus.i_resp_valid    = bus.t_resp_valid[i];
                        bus.i_resp_data     = bus.t_resp_data[i];
                        bus.t_resp_ready[i] = bus.i_resp_ready;
                    end
                end
            end
        end
    end

    assign push = bus.i_req_valid && bus.i_req_ready;
    assign pop  = bus.i_resp_valid && bus.i_resp_ready;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) ord_mem[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_ladybird_bus_router.sv
module tb_ladybird_bus_router;
    localparam int NT = 5;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    ladybird_bus_router_if #(.N_TARGET(NT), .ADDR_W(32), .DATA_W(32)) bus_a ();
    ladybird_bus_router_if #(.N_TARGET(NT), .ADDR_W(32), .DATA_W(32)) bus_b ();

    ladybird_bus_router dut_a (.clk(clk), .nrst(nrst), .bus(bus_a.slave));
    ladybird_bus_router #(.DEFAULT_TARGET(5), .MAX_OUTSTANDING(3)) dut_b (
        .clk(clk), .nrst(nrst), .bus(bus_b.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  trdy;
        logic [4:0]  exp_tv;
        logic        exp_rdy;
    } dec_vec_t;
    dec_vec_t dec_tbl [7];

    typedef struct {
        int          tgt;
        logic [31:0] data;
    } pend_t;
    pend_t gq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region decode straight from the address map: lowest enabled matching tag, else default.
    function automatic int ref_sel(input logic [31:0] addr, input int dflt);
        logic [3:0] tags [5];
        bit         en [5];
        tags = '{4'h9, 4'h8, 4'h0, 4'hF, 4'hE};
        en   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++)
            if (en[i] && addr[31:28] == tags[i]) return i;
        return dflt;
    endfunction

    task automatic issue_a(input logic [31:0] addr, input string name);
        @(negedge clk);
        bus_a.i_req_valid = 1'b1;
        bus_a.i_req_addr  = addr;
        #1 check(name, bus_a.i_req_ready, 1'b1);
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
    endtask

    task automatic rand_cycle(input bit drain);
        int          es;
        int          h;
        logic [3:0]  tag_pool [8];
        logic [4:0]  exp_tv;
        logic [4:0]  exp_trr;
        logic        exp_rdy;
        logic        exp_rv;
        logic [31:0] a;
        pend_t       p;
        tag_pool = '{4'h9, 4'h8, 4'h0, 4'hF, 4'hE, 4'h2, 4'h7, 4'hC};
        @(negedge clk);
        a = $urandom;
        a[31:28] = tag_pool[$urandom_range(0, 7)];
        bus_a.i_req_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
        bus_a.i_req_addr   = a;
        bus_a.i_req_wdata  = $urandom;
        bus_a.i_req_wstrb  = 4'($urandom);
        bus_a.i_req_write  = 1'($urandom);
        bus_a.t_req_ready  = 5'($urandom);
        bus_a.i_resp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int i = 0; i < NT; i++) begin
            bus_a.t_resp_valid[i] = 1'b0;
            bus_a.t_resp_data[i]  = $urandom;
            for (int k = 0; k < gq.size(); k++) begin
                if (gq[k].tgt == i) begin
                    bus_a.t_resp_valid[i] = drain ? 1'b1 : 1'($urandom_range(0, 1));
                    bus_a.t_resp_data[i]  = gq[k].data;
                    break;
                end
            end
        end
        #1;
        es      = ref_sel(a, 2);
        exp_rdy = (gq.size() < 4) && bus_a.t_req_ready[es];
        exp_tv  = (gq.size() < 4 && bus_a.i_req_valid) ? 5'(1 << es) : 5'b0;
        check("rnd_i_req_ready", bus_a.i_req_ready, exp_rdy);
        check("rnd_t_req_valid", bus_a.t_req_valid, exp_tv);
        check("rnd_t_req_addr", bus_a.t_req_addr, a);
        exp_rv  = 1'b0;
        exp_trr = '0;
        if (gq.size() > 0) begin
            h       = gq[0].tgt;
            exp_rv  = bus_a.t_resp_valid[h];
            exp_trr = bus_a.i_resp_ready ? 5'(1 << h) : 5'b0;
        end
        check("rnd_i_resp_valid", bus_a.i_resp_valid, exp_rv);
        check("rnd_t_resp_ready", bus_a.t_resp_ready, exp_trr);
        if (exp_rv) begin
            check("rnd_i_resp_data", bus_a.i_resp_data, gq[0].data);
            check("rnd_i_resp_error", bus_a.i_resp_error, 1'b0);
        end
        if (exp_rv && bus_a.i_resp_ready) void'(gq.pop_front());
        if (bus_a.i_req_valid && exp_rdy) begin
            p.tgt  = es;
            p.data = $urandom;
            gq.push_back(p);
        end
    endtask

    initial begin
        dec_tbl[0] = '{32'hF000_0000, 5'h1F, 5'b01000, 1'b1};
        dec_tbl[1] = '{32'hE000_0010, 5'h1F, 5'b10000, 1'b1};
        dec_tbl[2] = '{32'h8000_0000, 5'h1F, 5'b00010, 1'b1};
        dec_tbl[3] = '{32'h9000_0004, 5'h1F, 5'b00001, 1'b1};
        dec_tbl[4] = '{32'h1234_5678, 5'h1F, 5'b00100, 1'b1};
        dec_tbl[5] = '{32'h0000_0040, 5'h1F, 5'b00100, 1'b1};
        dec_tbl[6] = '{32'hF000_0008, 5'b10111, 5'b01000, 1'b0};

        nrst = 1'b0;
        bus_a.i_req_valid = 1'b1;  bus_a.i_req_addr = 32'hF000_0000;
        bus_a.i_req_wdata = '0;    bus_a.i_req_wstrb = '0; bus_a.i_req_write = 1'b0;
        bus_a.i_resp_ready = 1'b1; bus_a.t_req_ready = '1;
        bus_a.t_resp_valid = '0;   bus_a.t_resp_data = '0;
        bus_b.i_req_valid = 1'b1;  bus_b.i_req_addr = 32'h3000_0000;
        bus_b.i_req_wdata = '0;    bus_b.i_req_wstrb = '0; bus_b.i_req_write = 1'b0;
        bus_b.i_resp_ready = 1'b1; bus_b.t_req_ready = '1;
        bus_b.t_resp_valid = '0;   bus_b.t_resp_data = '0;

        #2;
        check("rst_i_req_ready", bus_a.i_req_ready, 1'b0);
        check("rst_t_req_valid", bus_a.t_req_valid, 5'b0);
        check("rst_i_resp_valid", bus_a.i_resp_valid, 1'b0);
        check("rst_i_resp_data", bus_a.i_resp_data, 32'h0);
        check("rst_i_resp_error", bus_a.i_resp_error, 1'b0);
        check("rst_t_resp_ready", bus_a.t_resp_ready, 5'b0);
        check("rst_err_i_req_ready", bus_b.i_req_ready, 1'b0);
        check("rst_err_i_resp_valid", bus_b.i_resp_valid, 1'b0);

        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        bus_b.i_req_valid = 1'b0;
        nrst = 1'b1;

        // Decode sweep: present the request and withdraw it before the clock edge.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            bus_a.i_req_addr  = dec_tbl[v].addr;
            bus_a.t_req_ready = dec_tbl[v].trdy;
            bus_a.i_req_valid = 1'b1;
            #1;
            check($sformatf("dec%0d_t_req_valid", v), bus_a.t_req_valid, dec_tbl[v].exp_tv);
            check($sformatf("dec%0d_i_req_ready", v), bus_a.i_req_ready, dec_tbl[v].exp_rdy);
            bus_a.i_req_valid = 1'b0;
        end
        bus_a.t_req_ready = '1;

        // Ordering: BRAM then DRAM; DRAM answers first and must wait.
        issue_a(32'h8000_0000, "ord_issue_bram");
        issue_a(32'h2000_0000, "ord_issue_dram");
        @(negedge clk);
        bus_a.t_resp_valid[2] = 1'b1;
        bus_a.t_resp_data[2]  = 32'h0000_BBBB;
        #1;
        check("ord_dram_blocked_valid", bus_a.i_resp_valid, 1'b0);
        check("ord_dram_blocked_ready", bus_a.t_resp_ready[2], 1'b0);
        @(negedge clk);
        #1 check("ord_dram_still_blocked", bus_a.t_resp_ready[2], 1'b0);
        bus_a.t_resp_valid[1] = 1'b1;
        bus_a.t_resp_data[1]  = 32'h0000_AAAA;
        #1;
        check("ord_first_valid", bus_a.i_resp_valid, 1'b1);
        check("ord_first_data", bus_a.i_resp_data, 32'h0000_AAAA);
        check("ord_first_t_resp_ready", bus_a.t_resp_ready, 5'b00010);
        @(negedge clk);
        bus_a.t_resp_valid[1] = 1'b0;
        #1;
        check("ord_second_valid", bus_a.i_resp_valid, 1'b1);
        check("ord_second_data", bus_a.i_resp_data, 32'h0000_BBBB);
        check("ord_second_t_resp_ready", bus_a.t_resp_ready, 5'b00100);
        @(negedge clk);
        bus_a.t_resp_valid[2] = 1'b0;
        #1 check("ord_empty", bus_a.i_resp_valid, 1'b0);

        // Full stall: four DRAM reads outstanding block the fifth until one pops.
        for (int k = 0; k < 4; k++) issue_a(32'h2000_0000 + 32'(k * 4), $sformatf("full_issue%0d", k));
        @(negedge clk);
        bus_a.i_req_valid = 1'b1;
        bus_a.i_req_addr  = 32'h2000_0100;
        #1;
        check("full_i_req_ready", bus_a.i_req_ready, 1'b0);
        check("full_t_req_valid", bus_a.t_req_valid, 5'b0);
        bus_a.t_resp_valid[2] = 1'b1;
        bus_a.t_resp_data[2]  = 32'h0000_0100;
        #1;
        check("full_pop_valid", bus_a.i_resp_valid, 1'b1);
        check("full_pop_no_unblock", bus_a.i_req_ready, 1'b0);
        @(negedge clk);
        bus_a.t_resp_valid[2] = 1'b0;
        #1;
        check("full_after_pop_ready", bus_a.i_req_ready, 1'b1);
        check("full_after_pop_t_req_valid", bus_a.t_req_valid, 5'b00100);
        @(negedge clk);
        bus_a.i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_a.t_resp_valid[2] = 1'b1;
            #1 check($sformatf("full_drain%0d", k), bus_a.i_resp_valid, 1'b1);
            @(negedge clk);
        end
        bus_a.t_resp_valid[2] = 1'b0;
        #1 check("full_drained", bus_a.i_resp_valid, 1'b0);

        // Error target on dut_b: accepted at once, answered next cycle, stable while stalled.
        @(negedge clk);
        bus_b.i_resp_ready = 1'b0;
        bus_b.i_req_valid  = 1'b1;
        bus_b.i_req_addr   = 32'h3000_0000;
        #1;
        check("err_accept_ready", bus_b.i_req_ready, 1'b1);
        check("err_no_target", bus_b.t_req_valid, 5'b0);
        check("err_not_yet_valid", bus_b.i_resp_valid, 1'b0);
        @(negedge clk);
        bus_b.i_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("err_valid%0d", k), bus_b.i_resp_valid, 1'b1);
            check($sformatf("err_flag%0d", k), bus_b.i_resp_error, 1'b1);
            check($sformatf("err_data%0d", k), bus_b.i_resp_data, 32'h0);
            @(negedge clk);
        end
        bus_b.i_resp_ready = 1'b1;
        @(negedge clk);
        #1 check("err_popped", bus_b.i_resp_valid, 1'b0);

        // Wrap on depth 3: push and pop every cycle, BRAM answers one cycle after each request.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            bus_b.i_req_valid = (k < 10);
            bus_b.i_req_addr  = 32'h8000_0000 + 32'(k * 4);
            bus_b.t_resp_valid[1] = (k > 0);
            bus_b.t_resp_data[1]  = 32'hC0DE_0000 + 32'(k - 1);
            #1;
            if (k < 10) begin
                check($sformatf("wrap_req_ready%0d", k), bus_b.i_req_ready, 1'b1);
                check($sformatf("wrap_t_req_valid%0d", k), bus_b.t_req_valid, 5'b00010);
            end
            if (k > 0) begin
                check($sformatf("wrap_resp_valid%0d", k), bus_b.i_resp_valid, 1'b1);
                check($sformatf("wrap_resp_data%0d", k), bus_b.i_resp_data, 32'hC0DE_0000 + 32'(k - 1));
            end
        end
        @(negedge clk);
        bus_b.i_req_valid  = 1'b0;
        bus_b.t_resp_valid = '0;
        #1 check("wrap_empty", bus_b.i_resp_valid, 1'b0);

        // Randomised traffic against the in-order reference queue, then drain.
        for (int c = 0; c < 1500; c++) rand_cycle(1'b0);
        for (int c = 0; c < 40 && gq.size() > 0; c++) rand_cycle(1'b1);
        check("rnd_model_drained", gq.size(), 0);
        @(negedge clk);
        bus_a.i_req_valid  = 1'b0;
        bus_a.t_resp_valid = '0;
        bus_a.t_req_ready  = '1;
        bus_a.i_resp_ready = 1'b1;
        #1 check("rnd_dut_empty", bus_a.i_resp_valid, 1'b0);

        // Reset mid-operation with two DRAM reads in flight.
        issue_a(32'h2000_0000, "rst_issue0");
        issue_a(32'h2000_0004, "rst_issue1");
        @(negedge clk);
        bus_a.i_resp_ready    = 1'b0;
        bus_a.t_resp_valid[2] = 1'b1;
        bus_a.t_resp_data[2]  = 32'h0000_5555;
        bus_a.i_req_valid     = 1'b1;
        bus_a.i_req_addr      = 32'h9000_0004;
        #1 check("mid_pre_valid", bus_a.i_resp_valid, 1'b1);
        nrst = 1'b0;
        #1;
        check("mid_rst_resp_valid", bus_a.i_resp_valid, 1'b0);
        check("mid_rst_resp_data", bus_a.i_resp_data, 32'h0);
        check("mid_rst_t_resp_ready", bus_a.t_resp_ready, 5'b0);
        check("mid_rst_req_ready", bus_a.i_req_ready, 1'b0);
        check("mid_rst_t_req_valid", bus_a.t_req_valid, 5'b0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("mid_post_empty", bus_a.i_resp_valid, 1'b0);
        check("mid_post_req_ready", bus_a.i_req_ready, 1'b1);
        check("mid_post_t_req_valid", bus_a.t_req_valid, 5'b00001);
        @(negedge clk);
        bus_a.i_req_valid     = 1'b0;
        bus_a.i_resp_ready    = 1'b1;
        bus_a.t_resp_valid[0] = 1'b1;
        bus_a.t_resp_data[0]  = 32'h0000_1234;
        #1;
        check("mid_new_valid", bus_a.i_resp_valid, 1'b1);
        check("mid_new_data", bus_a.i_resp_data, 32'h0000_1234);
        check("mid_new_t_resp_ready", bus_a.t_resp_ready, 5'b00001);
        @(negedge clk);
        bus_a.t_resp_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
